// File: rtl/ps2_key_pkg.sv
// Shared types and scancode constants for the PS/2 key tracker.
// Holds the scancode FSM states, the prefix bytes and the make/arrow lookup tables.
package ps2_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_e;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Entry 0 sits in the low byte: keys 0..7 = 1C,1B,23,2B,1D,24,29,5A.
  localparam logic [7:0][7:0] MAKE_TABLE = {
    8'h5A, 8'h29, 8'h24, 8'h1D, 8'h2B, 8'h23, 8'h1B, 8'h1C
  };

  // Extended arrows for keys 0..3: left, down, right, up.
  localparam logic [3:0][7:0] ARROW_TABLE = {8'h75, 8'h74, 8'h72, 8'h6B};

  function automatic logic make_match(input logic [7:0] code, input logic [2:0] idx);
    return code == MAKE_TABLE[idx];
  endfunction

  function automatic logic arrow_match(input logic [7:0] code, input logic [1:0] idx);
    return code == ARROW_TABLE[idx];
  endfunction

endpackage

// File: rtl/ps2_tick_gen.sv
// Free-running clock-enable generator: tick_o pulses for one cycle every DIV clocks.
module ps2_tick_gen #(
  parameter int DIV = 2500000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: clocked state is always written with <= so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst)                r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign tick_o = (r_cnt == LAST);

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 key tracker: prefix FSM, per-key held state, press and auto-repeat pulses.
// Define EXT_ARROWS_EN to map E0-prefixed arrow codes onto keys 0..3.
module ps2_key_tracker
  import ps2_key_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int TICK_DIV     = 2500000,
  parameter int REPEAT_DELAY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        code_i,
  input  logic              code_valid_i,
  output logic [N_KEYS-1:0] held_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] cmd_o
);

  localparam logic [3:0] REP_LIM = 4'(REPEAT_DELAY);

  ps2_state_e        r_state, w_state_nxt;
  logic [N_KEYS-1:0] r_held, r_press, r_cmd;
  logic [3:0]        r_repcnt;
  logic [N_KEYS-1:0] w_tbl, w_make, w_break, w_new_press, w_held_nxt;
  logic              w_tick;
`ifdef EXT_ARROWS_EN
  logic [N_KEYS-1:0] w_arr;
`endif

  ps2_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (w_tick)
  );

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_make      = '0;
    w_break     = '0;
    w_tbl       = '0;
    for (int i = 0; i < N_KEYS; i++) w_tbl[i] = make_match(code_i, 3'(i));
`ifdef EXT_ARROWS_EN
    w_arr = '0;
    for (int i = 0; i < N_KEYS; i++) w_arr[i] = (i < 4) && arrow_match(code_i, 2'(i));
`endif
    if (code_valid_i) begin
      unique case (r_state)
        ST_IDLE: begin
          if      (code_i == SC_EXT) w_state_nxt = ST_EXT;
          else if (code_i == SC_BRK) w_state_nxt = ST_BRK;
          else                       w_make      = w_tbl;
        end
        ST_EXT: begin
          if (code_i == SC_BRK) w_state_nxt = ST_EXT_BRK;
          else begin
            w_state_nxt = ST_IDLE;
`ifdef EXT_ARROWS_EN
            w_make = w_arr;
`endif
          end
        end
        ST_BRK: begin
          if      (code_i == SC_BRK) w_state_nxt = ST_BRK;
          else if (code_i == SC_EXT) w_state_nxt = ST_EXT_BRK;
          else begin
            w_state_nxt = ST_IDLE;
            w_break     = w_tbl;
          end
        end
        ST_EXT_BRK: begin
          if (code_i != SC_BRK) begin
            w_state_nxt = ST_IDLE;
`ifdef EXT_ARROWS_EN
            w_break = w_arr;
`endif
          end
        end
      endcase
    end
  end

  assign w_new_press = w_make & ~r_held;
  assign w_held_nxt  = (r_held | w_make) & ~w_break;

  // A fresh press outranks a same-cycle repeat tick and restarts the hold delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_held   <= '0;
      r_press  <= '0;
      r_cmd    <= '0;
      r_repcnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_held  <= w_held_nxt;
      r_press <= w_new_press;
      if (|w_new_press) begin
        r_cmd    <= w_new_press;
        r_repcnt <= '0;
      end else if (r_held == '0) begin
        r_cmd    <= '0;
        r_repcnt <= '0;
      end else if (w_tick && (r_repcnt < REP_LIM)) begin
        r_cmd    <= '0;
        r_repcnt <= r_repcnt + 4'd1;
      end else if (w_tick) begin
        r_cmd <= r_held;
      end else begin
        r_cmd <= '0;
      end
    end
  end

  assign held_o  = r_held;
  assign press_o = r_press;
  assign cmd_o   = r_cmd;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker with TICK_DIV=10, REPEAT_DELAY=2, N_KEYS=4.
module tb_ps2_key_tracker;

  localparam int N_KEYS       = 4;
  localparam int TICK_DIV     = 10;
  localparam int REPEAT_DELAY = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        code_i;
  logic              code_valid_i;
  logic [N_KEYS-1:0] held_o, press_o, cmd_o;

  typedef struct packed {
    logic [3:0] held;
    logic [3:0] press;
    logic [3:0] cmd;
  } exp_t;

  exp_t sb[$];
  exp_t obs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tb_phase = 0;

  ps2_key_tracker #(
    .N_KEYS       (N_KEYS),
    .TICK_DIV     (TICK_DIV),
    .REPEAT_DELAY (REPEAT_DELAY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .code_i       (code_i),
    .code_valid_i (code_valid_i),
    .held_o       (held_o),
    .press_o      (press_o),
    .cmd_o        (cmd_o)
  );

  always #5 clk = ~clk;

  // Divider phase seen by the coming edge; a tick edge follows when it reads TICK_DIV-1.
  always @(posedge clk) begin
    if (rst) tb_phase <= 0;
    else     tb_phase <= (tb_phase == TICK_DIV - 1) ? 0 : tb_phase + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // One clock: drive at negedge, push the expectation, capture outputs at the next negedge.
  task automatic step(input logic r, input logic v, input logic [7:0] c,
                      input logic [3:0] eh, input logic [3:0] ep, input logic [3:0] ec);
    exp_t e;
    rst          = r;
    code_valid_i = v;
    code_i       = c;
    e.held = eh; e.press = ep; e.cmd = ec;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    obs.push_back({held_o, press_o, cmd_o});
    rst          = 1'b0;
    code_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, o;
    int idx = 0;
    step(1, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000);
    step(1, 1, 8'h1C, 4'b0000, 4'b0000, 4'b0000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got held=%b press=%b cmd=%b, expected held=%b press=%b cmd=%b",
                 idx, o.held, o.press, o.cmd, e.held, e.press, e.cmd);
      end
      idx++;
    end
  endtask

  task automatic test_press_release();
    exp_t e, o;
    int idx = 0;
    step(0, 1, 8'h1C, 4'b0001, 4'b0001, 4'b0001);
    step(0, 0, 8'h00, 4'b0001, 4'b0000, 4'b0000);
    step(0, 1, 8'h00, 4'b0001, 4'b0000, 4'b0000);
    step(0, 1, 8'h29, 4'b0001, 4'b0000, 4'b0000);
    step(0, 1, 8'hF0, 4'b0001, 4'b0000, 4'b0000);
    step(0, 1, 8'h1C, 4'b0000, 4'b0000, 4'b0000);
    step(0, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000);
    step(0, 1, 8'hF0, 4'b0000, 4'b0000, 4'b0000);
    step(0, 1, 8'h1B, 4'b0000, 4'b0000, 4'b0000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL press_release[%0d]: got held=%b press=%b cmd=%b, expected held=%b press=%b cmd=%b",
                 idx, o.held, o.press, o.cmd, e.held, e.press, e.cmd);
      end
      idx++;
    end
  endtask

  task automatic test_auto_repeat();
    exp_t e, o;
    int idx = 0, guard = 0, ticks = 0;
    logic t;
    while (tb_phase != 0 && guard < 2 * TICK_DIV) begin
      step(0, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000);
      guard++;
    end
    step(0, 1, 8'h2B, 4'b1000, 4'b1000, 4'b1000);
    for (int k = 0; k < 49; k++) begin
      t = (tb_phase == TICK_DIV - 1);
      if (t) ticks++;
      step(0, 0, 8'h00, 4'b1000, 4'b0000, (t && ticks > REPEAT_DELAY) ? 4'b1000 : 4'b0000);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL auto_repeat[%0d]: got held=%b press=%b cmd=%b, expected held=%b press=%b cmd=%b",
                 idx, o.held, o.press, o.cmd, e.held, e.press, e.cmd);
      end
      idx++;
    end
  endtask

  task automatic test_press_on_tick();
    exp_t e, o;
    int idx = 0, guard = 0, ticks = 0;
    logic t;
    while (tb_phase != TICK_DIV - 1 && guard < 2 * TICK_DIV) begin
      step(0, 0, 8'h00, 4'b1000, 4'b0000, 4'b0000);
      guard++;
    end
    step(0, 1, 8'h1C, 4'b1001, 4'b0001, 4'b0001);
    for (int k = 0; k < 3 * TICK_DIV; k++) begin
      t = (tb_phase == TICK_DIV - 1);
      if (t) ticks++;
      step(0, 0, 8'h00, 4'b1001, 4'b0000, (t && ticks > REPEAT_DELAY) ? 4'b1001 : 4'b0000);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL press_on_tick[%0d]: got held=%b press=%b cmd=%b, expected held=%b press=%b cmd=%b",
                 idx, o.held, o.press, o.cmd, e.held, e.press, e.cmd);
      end
      idx++;
    end
  endtask

  task automatic test_extended();
    exp_t e, o;
    int idx = 0;
    logic [3:0] up, held_after;
`ifdef EXT_ARROWS_EN
    up         = 4'b1000;
    held_after = 4'b0000;
`else
    up         = 4'b0000;
    held_after = 4'b0001;
`endif
    step(1, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000);
    step(0, 1, 8'hE0, 4'b0000, 4'b0000, 4'b0000);
    step(0, 1, 8'h75, up, up, up);
    step(0, 0, 8'h00, up, 4'b0000, 4'b0000);
    step(0, 1, 8'hE0, up, 4'b0000, 4'b0000);
    step(0, 1, 8'hF0, up, 4'b0000, 4'b0000);
    step(0, 1, 8'h75, 4'b0000, 4'b0000, 4'b0000);
    step(0, 1, 8'h1C, 4'b0001, 4'b0001, 4'b0001);
    step(0, 1, 8'hE0, 4'b0001, 4'b0000, 4'b0000);
    step(0, 1, 8'hF0, 4'b0001, 4'b0000, 4'b0000);
    step(0, 1, 8'h1C, 4'b0001, 4'b0000, 4'b0000);
    step(0, 1, 8'hE0, 4'b0001, 4'b0000, 4'b0000);
    step(0, 1, 8'hF0, 4'b0001, 4'b0000, 4'b0000);
    step(0, 1, 8'h6B, held_after, 4'b0000, 4'b0000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL extended[%0d]: got held=%b press=%b cmd=%b, expected held=%b press=%b cmd=%b",
                 idx, o.held, o.press, o.cmd, e.held, e.press, e.cmd);
      end
      idx++;
    end
  endtask

  task automatic test_prefix_reset();
    exp_t e, o;
    int idx = 0;
    step(1, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000);
    step(0, 1, 8'hF0, 4'b0000, 4'b0000, 4'b0000);
    step(1, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000);
    step(0, 1, 8'h1C, 4'b0001, 4'b0001, 4'b0001);
    step(0, 1, 8'h1C, 4'b0001, 4'b0000, 4'b0000);
    step(0, 1, 8'h1C, 4'b0001, 4'b0000, 4'b0000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL prefix_reset[%0d]: got held=%b press=%b cmd=%b, expected held=%b press=%b cmd=%b",
                 idx, o.held, o.press, o.cmd, e.held, e.press, e.cmd);
      end
      idx++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    int idx = 0;
    step(1, 0, 8'h00, 4'b0000, 4'b0000, 4'b0000);
    step(0, 1, 8'h1C, 4'b0001, 4'b0001, 4'b0001);
    step(0, 1, 8'h1B, 4'b0011, 4'b0010, 4'b0010);
    step(0, 1, 8'h23, 4'b0111, 4'b0100, 4'b0100);
    step(0, 1, 8'hF0, 4'b0111, 4'b0000, 4'b0000);
    step(0, 1, 8'hF0, 4'b0111, 4'b0000, 4'b0000);
    step(0, 1, 8'h1B, 4'b0101, 4'b0000, 4'b0000);
    step(0, 1, 8'hF0, 4'b0101, 4'b0000, 4'b0000);
    step(0, 1, 8'hE0, 4'b0101, 4'b0000, 4'b0000);
    step(0, 1, 8'h1C, 4'b0101, 4'b0000, 4'b0000);
    step(0, 1, 8'hF0, 4'b0101, 4'b0000, 4'b0000);
    step(0, 1, 8'h1C, 4'b0100, 4'b0000, 4'b0000);
    step(0, 1, 8'hF0, 4'b0100, 4'b0000, 4'b0000);
    step(0, 1, 8'h23, 4'b0000, 4'b0000, 4'b0000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got held=%b press=%b cmd=%b, expected held=%b press=%b cmd=%b",
                 idx, o.held, o.press, o.cmd, e.held, e.press, e.cmd);
      end
      idx++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    code_valid_i = 1'b0;
    code_i       = 8'h00;
    @(negedge clk);
    test_reset();
    test_press_release();
    test_auto_repeat();
    test_press_on_tick();
    test_extended();
    test_prefix_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
